// File: rtl/w_stream_serializer.sv
// w_stream_serializer
// Loads a parallel pattern on an accepted start and presents it MSB-first on w,
// holding each bit for DIV clock cycles. step marks the last cycle of each bit
// period (the cycle a consumer should sample w), busy covers the whole
// presentation and done pulses for one cycle after the final bit.
//
// Handshake: start is a level request that is only looked at in IDLE; the edge
// that sees start=1 in IDLE captures pattern and begins the transfer. There is
// no back-pressure -- once accepted, a transfer always runs to completion
// (unless reset), and start/pattern are ignored until the block is IDLE again.
//
// All outputs are registered: every value is computed one edge ahead from the
// next-state decision, so w/step/busy/done are glitch-free flop outputs.
module w_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             w,
  output logic             step,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(DIV + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  // With DIV=1 every bit period is a single cycle, so the first cycle of a
  // bit is already its step cycle.
  localparam logic          STEP_FIRST = (DIV == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic [DW-1:0]    r_div_cnt;
  logic             r_w;
  logic             r_step;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shreg_shl;
  logic [DW-1:0]    w_div_inc;
  logic [BW-1:0]    w_bit_inc;

  // Shifted pattern and counter increments used by the state machine.
  always_comb begin
    w_shreg_shl = r_shreg << 1;
    w_div_inc   = r_div_cnt + 1'b1;
    w_bit_inc   = r_bit_cnt + 1'b1;
  end

  // Transfer state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_w       <= 1'b0;
      r_step    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_SHIFT;
            r_shreg   <= pattern;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_w       <= pattern[WIDTH-1];
            r_step    <= STEP_FIRST;
            r_busy    <= 1'b1;
          end else begin
            r_w    <= 1'b0;
            r_step <= 1'b0;
            r_busy <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            // End of a bit period: advance to the next bit or finish.
            r_div_cnt <= '0;
            r_shreg   <= w_shreg_shl;
            r_bit_cnt <= w_bit_inc;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_DONE;
              r_w     <= 1'b0;
              r_step  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_w    <= w_shreg_shl[WIDTH-1];
              r_step <= STEP_FIRST;
            end
          end else begin
            // Still inside the bit period: hold w, flag the final cycle.
            r_div_cnt <= w_div_inc;
            r_step    <= (w_div_inc == DIV_LAST);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_w     <= 1'b0;
          r_step  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          // Unused encoding: drop straight back to a clean IDLE.
          r_state   <= S_IDLE;
          r_shreg   <= '0;
          r_bit_cnt <= '0;
          r_div_cnt <= '0;
          r_w       <= 1'b0;
          r_step    <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign w         = r_w;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_w_stream_serializer.sv
// Bench for w_stream_serializer: three instances cover WIDTH/DIV = 8/1, 8/4
// and 4/1. Only one instance is active at a time; a per-cycle expected queue
// of {w,step,busy,done} is filled from a small timing model when a transfer
// is started and drained one entry per clock.
module tb_w_stream_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic       start0, start1, start2;
  logic [7:0] pat0, pat1;
  logic [3:0] pat2;
  logic       w0, step0, busy0, done0;
  logic       w1, step1, busy1, done1;
  logic       w2, step2, busy2, done2;
  logic [1:0] dbg0, dbg1, dbg2;

  w_stream_serializer #(.WIDTH(8), .DIV(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .pattern(pat0),
    .w(w0), .step(step0), .busy(busy0), .done(done0), .dbg_state(dbg0)
  );
  w_stream_serializer #(.WIDTH(8), .DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .pattern(pat1),
    .w(w1), .step(step1), .busy(busy1), .done(done1), .dbg_state(dbg1)
  );
  w_stream_serializer #(.WIDTH(4), .DIV(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .pattern(pat2),
    .w(w2), .step(step2), .busy(busy2), .done(done2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];   // {w, step, busy, done} per cycle
  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;
  int cyc   = 0;

  function automatic int width_of(int s);
    return (s == 2) ? 4 : 8;
  endfunction

  function automatic int div_of(int s);
    return (s == 1) ? 4 : 1;
  endfunction

  // Expected outputs j cycles after the accepting edge (j=1 is the first cycle).
  function automatic logic [3:0] model(int width, int div, logic [7:0] pat, int j);
    int k;
    if (j >= 1 && j <= width * div) begin
      k = (j - 1) / div;
      return {pat[width-1-k], ((j - 1) % div) == (div - 1), 1'b1, 1'b0};
    end else if (j == width * div + 1) begin
      return 4'b0001;
    end
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] outs_of(int s);
    case (s)
      0:       return {w0, step0, busy0, done0};
      1:       return {w1, step1, busy1, done1};
      default: return {w2, step2, busy2, done2};
    endcase
  endfunction

  task automatic push_transfer(input int s, input logic [7:0] pat);
    int wd, dv;
    wd = width_of(s);
    dv = div_of(s);
    for (int j = 1; j <= wd * dv + 2; j++) exp_q.push_back(model(wd, dv, pat, j));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input int s, input logic v, input logic [7:0] pat);
    case (s)
      0:       begin start0 = v; pat0 = pat; end
      1:       begin start1 = v; pat1 = pat; end
      default: begin start2 = v; pat2 = pat[3:0]; end
    endcase
  endtask

  // One clock: cross the edge, sample 1 ns later, compare against the queue
  // head (an empty queue means the selected instance must be idle).
  task automatic tick(output logic [3:0] o);
    logic [3:0] e;
    @(posedge clk);
    #1;
    cyc++;
    o = outs_of(sel);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    check("sb_outputs", {28'd0, o}, {28'd0, e});
  endtask

  // ---------------- table ----------------
  typedef struct {
    int         sel;
    logic [7:0] pat;
    logic [7:0] exp_bits;   // w values seen on step cycles, first in MSB side
    int         exp_steps;
    int         exp_done;   // cycle of the done pulse, accept edge = cycle 0
    int         repulse;    // cycle at which start is re-pulsed with 8'hFF (0 = none)
  } vec_t;

  vec_t tbl[6];

  task automatic run_transfer(input vec_t v);
    logic [3:0] o;
    logic [7:0] got_bits;
    int nsteps, done_cyc, total;
    sel      = v.sel;
    got_bits = '0;
    nsteps   = 0;
    done_cyc = -1;
    total    = width_of(v.sel) * div_of(v.sel) + 2;
    cyc      = 0;
    push_transfer(v.sel, v.pat);
    drive_start(v.sel, 1'b1, v.pat);
    for (int c = 1; c <= total; c++) begin
      tick(o);
      if (c == 1) drive_start(v.sel, 1'b0, v.pat);
      if (v.repulse != 0 && c == v.repulse) drive_start(v.sel, 1'b1, 8'hFF);
      if (v.repulse != 0 && c == v.repulse + 1) drive_start(v.sel, 1'b0, 8'hFF);
      if (o[2]) begin
        got_bits = {got_bits[6:0], o[3]};
        nsteps++;
      end
      if (o[0]) done_cyc = c;
    end
    check("step_bits", {24'd0, got_bits}, {24'd0, v.exp_bits});
    check("step_count", nsteps, v.exp_steps);
    check("done_cycle", done_cyc, v.exp_done);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    logic [3:0] o;
    int done_seen[$];

    tbl[0] = '{sel: 0, pat: 8'b1011_0010, exp_bits: 8'b1011_0010, exp_steps: 8, exp_done: 9,  repulse: 0};
    tbl[1] = '{sel: 1, pat: 8'hA5,        exp_bits: 8'b1010_0101, exp_steps: 8, exp_done: 33, repulse: 0};
    tbl[2] = '{sel: 0, pat: 8'b1011_0010, exp_bits: 8'b1011_0010, exp_steps: 8, exp_done: 9,  repulse: 3};
    tbl[3] = '{sel: 2, pat: 8'h0C,        exp_bits: 8'h0C,        exp_steps: 4, exp_done: 5,  repulse: 0};
    tbl[4] = '{sel: 1, pat: 8'h3C,        exp_bits: 8'b0011_1100, exp_steps: 8, exp_done: 33, repulse: 0};
    tbl[5] = '{sel: 0, pat: 8'h6E,        exp_bits: 8'b0110_1110, exp_steps: 8, exp_done: 9,  repulse: 0};

    reset  = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    pat0   = '0;   pat1   = '0;   pat2   = '0;
    #12;
    check("reset_outs0", {28'd0, w0, step0, busy0, done0}, 32'd0);
    check("reset_outs1", {28'd0, w1, step1, busy1, done1}, 32'd0);
    check("reset_outs2", {28'd0, w2, step2, busy2, done2}, 32'd0);
    check("reset_state0", {30'd0, dbg0}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(o);

    // Table-driven transfers (includes the ignored mid-transfer re-pulse).
    for (int i = 0; i < 6; i++) begin
      run_transfer(tbl[i]);
      for (int j = 0; j < 2; j++) tick(o);
    end

    // Reset mid-transfer: outputs clear immediately, then stay idle.
    sel = 0;
    cyc = 0;
    push_transfer(0, 8'b1011_0010);
    drive_start(0, 1'b1, 8'b1011_0010);
    tick(o);
    drive_start(0, 1'b0, 8'b1011_0010);
    tick(o);
    tick(o);
    #3 reset = 1'b1;
    #1;
    check("async_reset_outs", {28'd0, w0, step0, busy0, done0}, 32'd0);
    check("async_reset_state", {30'd0, dbg0}, 32'd0);
    exp_q.delete();
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(o);

    // Fresh transfer after that reset.
    run_transfer('{sel: 0, pat: 8'h81, exp_bits: 8'b1000_0001, exp_steps: 8, exp_done: 9, repulse: 0});
    tick(o);

    // start held high: back-to-back transfers every WIDTH*DIV+2 cycles.
    sel = 2;
    cyc = 0;
    for (int t = 0; t < 3; t++) push_transfer(2, 8'h0C);
    drive_start(2, 1'b1, 8'h0C);
    for (int c = 1; c <= 18; c++) begin
      tick(o);
      if (c == 17) drive_start(2, 1'b0, 8'h0C);
      if (o[0]) done_seen.push_back(c);
    end
    check("held_done_count", done_seen.size(), 3);
    while (done_seen.size() < 3) done_seen.push_back(-1);
    check("held_done_0", done_seen[0], 5);
    check("held_done_1", done_seen[1], 11);
    check("held_done_2", done_seen[2], 17);
    for (int i = 0; i < 3; i++) tick(o);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
